// File: rtl/rs_alu_station.sv
// rs_alu_station: integer-ALU reservation station with CDB wakeup and oldest-first select
module rs_alu_station #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 5,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_en,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [TAG_W-1:0]  disp_dst_tag,
  input  logic              disp_s1_rdy,
  input  logic [TAG_W-1:0]  disp_s1_tag,
  input  logic [DATA_W-1:0] disp_s1_val,
  input  logic              disp_s2_rdy,
  input  logic [TAG_W-1:0]  disp_s2_tag,
  input  logic [DATA_W-1:0] disp_s2_val,
  output logic              rs_full,
  output logic [CW-1:0]     rs_count,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [OP_W-1:0]   iss_op,
  output logic [DATA_W-1:0] iss_a,
  output logic [DATA_W-1:0] iss_b,
  output logic [TAG_W-1:0]  iss_tag
);
  localparam int AW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0]  v, r1, r2;
  logic [OP_W-1:0]   op_q  [DEPTH];
  logic [TAG_W-1:0]  dst_q [DEPTH];
  logic [TAG_W-1:0]  t1_q  [DEPTH];
  logic [TAG_W-1:0]  t2_q  [DEPTH];
  logic [DATA_W-1:0] d1_q  [DEPTH];
  logic [DATA_W-1:0] d2_q  [DEPTH];
  logic [AW-1:0]     age_q [DEPTH];
  logic [AW-1:0]     age_ctr;
  logic [IW-1:0]     free_idx, sel_idx;
  logic              free_found, sel_found, do_disp, do_iss;
  logic              s1_hit, s2_hit;

  // a is older than b when the modular distance a-b is negative
  function automatic logic older(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW-1:0] d;
    d = a - b;
    return d[AW-1];
  endfunction

  // lowest free slot and oldest entry with both operands ready
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!v[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (v[i] && r1[i] && r2[i] && (!sel_found || older(age_q[i], age_q[sel_idx]))) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign rs_full   = rs_count == CW'(DEPTH);
  assign do_disp   = disp_en && !rs_full && !flush;
  assign iss_valid = sel_found;
  assign do_iss    = iss_valid && iss_ready;
  assign iss_op    = sel_found ? op_q[sel_idx]  : '0;
  assign iss_a     = sel_found ? d1_q[sel_idx]  : '0;
  assign iss_b     = sel_found ? d2_q[sel_idx]  : '0;
  assign iss_tag   = sel_found ? dst_q[sel_idx] : '0;
  assign s1_hit    = cdb_valid && cdb_tag == disp_s1_tag;
  assign s2_hit    = cdb_valid && cdb_tag == disp_s2_tag;

  // occupancy, valid bits and the free-running age counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v        <= '0;
      rs_count <= '0;
      age_ctr  <= '0;
    end else if (flush) begin
      v        <= '0;
      rs_count <= '0;
    end else begin
      if (do_iss) v[sel_idx] <= 1'b0;
      if (do_disp) begin
        v[free_idx] <= 1'b1;
        age_ctr     <= age_ctr + 1'b1;
      end
      rs_count <= rs_count + CW'(do_disp) - CW'(do_iss);
    end
  end

  // entry payload: dispatch write with CDB bypass, otherwise snoop the CDB
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_disp && free_idx == IW'(i)) begin
        op_q[i]  <= disp_op;
        dst_q[i] <= disp_dst_tag;
        age_q[i] <= age_ctr;
        t1_q[i]  <= disp_s1_tag;
        t2_q[i]  <= disp_s2_tag;
        r1[i]    <= disp_s1_rdy || s1_hit;
        r2[i]    <= disp_s2_rdy || s2_hit;
        d1_q[i]  <= disp_s1_rdy ? disp_s1_val : s1_hit ? cdb_data : disp_s1_val;
        d2_q[i]  <= disp_s2_rdy ? disp_s2_val : s2_hit ? cdb_data : disp_s2_val;
      end else if (v[i]) begin
        if (cdb_valid && !r1[i] && t1_q[i] == cdb_tag) begin
          r1[i]   <= 1'b1;
          d1_q[i] <= cdb_data;
        end
        if (cdb_valid && !r2[i] && t2_q[i] == cdb_tag) begin
          r2[i]   <= 1'b1;
          d2_q[i] <= cdb_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_alu_station.sv
// tb_rs_alu_station: directed self-checking bench for the ALU reservation station
module tb_rs_alu_station;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, disp_en = 1'b0;
  logic [4:0]  disp_op = '0;
  logic [3:0]  disp_dst_tag = '0, disp_s1_tag = '0, disp_s2_tag = '0, cdb_tag = '0;
  logic        disp_s1_rdy = 1'b0, disp_s2_rdy = 1'b0, cdb_valid = 1'b0, iss_ready = 1'b0;
  logic [31:0] disp_s1_val = '0, disp_s2_val = '0, cdb_data = '0;
  logic        rs_full, iss_valid;
  logic [2:0]  rs_count;
  logic [4:0]  iss_op;
  logic [31:0] iss_a, iss_b;
  logic [3:0]  iss_tag;
  int tests = 0, fails = 0;

  rs_alu_station #(.DEPTH(4), .DATA_W(32), .TAG_W(4), .OP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .disp_en(disp_en), .disp_op(disp_op),
    .disp_dst_tag(disp_dst_tag), .disp_s1_rdy(disp_s1_rdy), .disp_s1_tag(disp_s1_tag),
    .disp_s1_val(disp_s1_val), .disp_s2_rdy(disp_s2_rdy), .disp_s2_tag(disp_s2_tag),
    .disp_s2_val(disp_s2_val), .rs_full(rs_full), .rs_count(rs_count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_a(iss_a), .iss_b(iss_b), .iss_tag(iss_tag)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dispatch(input logic [4:0] op, input logic [3:0] dst,
                          input logic s1r, input logic [3:0] s1t, input logic [31:0] s1v,
                          input logic [31:0] s2v);
    disp_en = 1'b1;
    disp_op = op;
    disp_dst_tag = dst;
    disp_s1_rdy = s1r;
    disp_s1_tag = s1t;
    disp_s1_val = s1v;
    disp_s2_rdy = 1'b1;
    disp_s2_tag = 4'd0;
    disp_s2_val = s2v;
    tick();
    disp_en = 1'b0;
  endtask

  task automatic broadcast(input logic [3:0] t, input logic [31:0] d);
    cdb_valid = 1'b1;
    cdb_tag = t;
    cdb_data = d;
    tick();
    cdb_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_count", 32'(rs_count), 0);
    chk("rst_full", 32'(rs_full), 0);
    chk("rst_valid", 32'(iss_valid), 0);
    chk("rst_a", iss_a, 0);
    chk("rst_tag", 32'(iss_tag), 0);
    rst_n = 1'b1;
    tick();

    // single ready instruction
    dispatch(5'd1, 4'd3, 1'b1, 4'd0, 32'd5, 32'd7);
    chk("t1_valid", 32'(iss_valid), 1);
    chk("t1_a", iss_a, 5);
    chk("t1_b", iss_b, 7);
    chk("t1_tag", 32'(iss_tag), 3);
    chk("t1_op", 32'(iss_op), 1);
    chk("t1_count1", 32'(rs_count), 1);
    iss_ready = 1'b1;
    tick();
    chk("t1_count0", 32'(rs_count), 0);
    chk("t1_empty", 32'(iss_valid), 0);
    iss_ready = 1'b0;

    // fill with entries waiting on tag 9, then wake them all at once
    for (int k = 0; k < 4; k++) dispatch(5'd2, 4'(10 + k), 1'b0, 4'd9, 32'd0, 32'(k));
    chk("t2_full", 32'(rs_full), 1);
    chk("t2_count", 32'(rs_count), 4);
    chk("t2_novalid", 32'(iss_valid), 0);
    broadcast(4'd9, 32'h55);
    chk("t2_full_held", 32'(rs_full), 1);
    iss_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_valid", 32'(iss_valid), 1);
      chk("t2_tag", 32'(iss_tag), 32'(10 + k));
      chk("t2_a", iss_a, 32'h55);
      chk("t2_b", iss_b, 32'(k));
      tick();
      if (k == 0) chk("t2_full_drop", 32'(rs_full), 0);
    end
    chk("t2_drained", 32'(rs_count), 0);
    iss_ready = 1'b0;

    // dispatch-cycle CDB bypass
    cdb_valid = 1'b1;
    cdb_tag = 4'd2;
    cdb_data = 32'hAA;
    dispatch(5'd3, 4'd5, 1'b0, 4'd2, 32'h0, 32'd1);
    cdb_valid = 1'b0;
    chk("t3_valid", 32'(iss_valid), 1);
    chk("t3_a", iss_a, 32'hAA);
    chk("t3_tag", 32'(iss_tag), 5);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    chk("t3_count", 32'(rs_count), 0);

    // dispatch into a full station while an issue frees a slot
    for (int k = 0; k < 4; k++) dispatch(5'd4, 4'(k), 1'b1, 4'd0, 32'(16 + k), 32'd0);
    chk("t4_full", 32'(rs_full), 1);
    disp_en = 1'b1;
    disp_dst_tag = 4'd7;
    iss_ready = 1'b1;
    chk("t4_drop_flag", 32'(rs_full & disp_en), 1);
    tick();
    disp_en = 1'b0;
    chk("t4_count", 32'(rs_count), 3);
    chk("t4_notfull", 32'(rs_full), 0);
    for (int k = 1; k < 4; k++) begin
      chk("t4_order", 32'(iss_tag), 32'(k));
      chk("t4_a", iss_a, 32'(16 + k));
      tick();
    end
    chk("t4_no_dropped", 32'(iss_valid), 0);
    chk("t4_empty", 32'(rs_count), 0);
    iss_ready = 1'b0;

    // flush with a simultaneous dispatch
    for (int k = 0; k < 3; k++) dispatch(5'd5, 4'(k), 1'b0, 4'd6, 32'd0, 32'd0);
    chk("t5_count3", 32'(rs_count), 3);
    flush = 1'b1;
    dispatch(5'd5, 4'd8, 1'b1, 4'd0, 32'd1, 32'd1);
    flush = 1'b0;
    chk("t5_count0", 32'(rs_count), 0);
    chk("t5_novalid", 32'(iss_valid), 0);
    broadcast(4'd6, 32'h66);
    chk("t5_no_issue", 32'(iss_valid), 0);

    // held presentation, then rounds that wrap the age counter
    dispatch(5'd6, 4'd1, 1'b1, 4'd0, 32'h11, 32'd0);
    dispatch(5'd6, 4'd2, 1'b1, 4'd0, 32'h22, 32'd0);
    for (int c = 0; c < 5; c++) begin
      chk("t6_hold_tag", 32'(iss_tag), 1);
      chk("t6_hold_a", iss_a, 32'h11);
      tick();
    end
    iss_ready = 1'b1;
    chk("t6_first", 32'(iss_tag), 1);
    tick();
    chk("t6_second", 32'(iss_tag), 2);
    tick();
    iss_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      dispatch(5'd7, 4'(4 * r), 1'b0, 4'd9, 32'd0, 32'd0);
      dispatch(5'd7, 4'(4 * r + 1), 1'b1, 4'd0, 32'd1, 32'd0);
      dispatch(5'd7, 4'(4 * r + 2), 1'b1, 4'd0, 32'd2, 32'd0);
      chk("t6_young_first", 32'(iss_tag), 32'(4 * r + 1));
      broadcast(4'd9, 32'(100 + r));
      chk("t6_older_takes", 32'(iss_tag), 32'(4 * r));
      chk("t6_older_a", iss_a, 32'(100 + r));
      iss_ready = 1'b1;
      tick();
      chk("t6_order1", 32'(iss_tag), 32'(4 * r + 1));
      tick();
      chk("t6_order2", 32'(iss_tag), 32'(4 * r + 2));
      tick();
      iss_ready = 1'b0;
      chk("t6_round_empty", 32'(rs_count), 0);
    end

    // asynchronous reset in the middle of a cycle
    dispatch(5'd8, 4'd9, 1'b1, 4'd0, 32'd3, 32'd4);
    chk("t7_pre", 32'(iss_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_valid", 32'(iss_valid), 0);
    chk("t7_async_count", 32'(rs_count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t7_after", 32'(iss_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
